// File: rtl/axis_demux_decoder.sv
// AXI-stream demultiplexer: decodes a per-packet binary destination index into a
// one-hot output valid, locking the destination for the whole packet; out-of-range packets are dropped.
module axis_demux_decoder #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 16,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          s_axis_tlast,
    input  logic [IW-1:0] s_axis_tid,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tlast,
    output logic [N-1:0]  m_axis_tvalid,
    input  logic [N-1:0]  m_axis_tready,
    output logic          drop,
    output logic [15:0]   drop_count
);

    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] lock_id;
    logic          rdy_en;
    logic          in_range_c;
    logic          drain_c;
    logic          accept_c;
    logic          load_c;
    logic          discard_first_c;
    logic [IW-1:0] load_idx_c;

    assign in_range_c = (32'(s_axis_tid) < N);
    assign drain_c    = ((m_axis_tready & m_axis_tvalid) != '0);

    // Ready: a discarded beat never needs ORB space; a routed one needs an empty or draining ORB.
    assign s_axis_tready = rdy_en && ((state == DROP) || (state == IDLE && !in_range_c) ||
                                      (m_axis_tvalid == '0) || drain_c);
    assign accept_c      = s_axis_tvalid && s_axis_tready;
    assign load_idx_c    = (state == IDLE) ? s_axis_tid : lock_id;

    // Next-state and per-beat decode.
    always_comb begin
        state_next      = state;
        load_c          = 1'b0;
        discard_first_c = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (in_range_c) begin
                        load_c = 1'b1;
                        if (!s_axis_tlast) state_next = ROUTE;
                    end else begin
                        discard_first_c = 1'b1;
                        if (!s_axis_tlast) state_next = DROP;
                    end
                end
            end
            ROUTE: begin
                if (accept_c) begin
                    load_c = 1'b1;
                    if (s_axis_tlast) state_next = IDLE;
                end
            end
            DROP: begin
                if (accept_c && s_axis_tlast) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lock_id <= '0;
            rdy_en  <= 1'b0;
        end else begin
            state  <= state_next;
            rdy_en <= 1'b1;
            if (state == IDLE && load_c) lock_id <= s_axis_tid;
        end
    end

    // Output register: a load replaces contents even while draining, giving full throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= '0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load_c) begin
            m_axis_tvalid <= N'(1) << load_idx_c;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tlast  <= s_axis_tlast;
        end else if (drain_c) begin
            m_axis_tvalid <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop       <= 1'b0;
            drop_count <= '0;
        end else begin
            drop <= discard_first_c;
            if (discard_first_c && drop_count != {CW{1'b1}}) drop_count <= drop_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_axis_demux_decoder.sv
// Scoreboard bench for axis_demux_decoder (N=3 so that index 3 is out of range).
module tb_axis_demux_decoder;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [IW-1:0] s_axis_tid;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic [N-1:0]  m_axis_tvalid;
    logic [N-1:0]  m_axis_tready;
    logic          drop;
    logic [15:0]   drop_count;

    axis_demux_decoder #(.N(N), .DW(DW), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .drop(drop), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            dest;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t        exp_q[$];
    int           n_checks    = 0;
    int           n_fail      = 0;
    int           exp_drops   = 0;
    int           drop_pulses = 0;
    logic         bp_hold     = 1'b0;
    logic [N-1:0] bp_val      = '0;
    logic         rand_ready  = 1'b0;
    logic         bp_done;

    // Downstream ready driver.
    initial m_axis_tready = '1;
    always @(posedge clk) begin
        #1;
        if (bp_hold)         m_axis_tready = bp_val;
        else if (rand_ready) m_axis_tready = N'($urandom);
        else                 m_axis_tready = '1;
    end

    // Monitor: pops the scoreboard on each downstream handshake, checks one-hot and stall stability.
    logic [N-1:0]  prev_v;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    logic          prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            beat_t e;
            if (drop) drop_pulses++;
            if (m_axis_tvalid != '0) begin
                n_checks++;
                if (!$onehot(m_axis_tvalid)) begin
                    n_fail++;
                    $display("FAIL onehot: tvalid=%b", m_axis_tvalid);
                end
            end
            if (prev_stall) begin
                n_checks++;
                if (m_axis_tvalid != prev_v || m_axis_tdata != prev_d || m_axis_tlast != prev_l) begin
                    n_fail++;
                    $display("FAIL stall_stable: got v=%b d=%h l=%b, held v=%b d=%h l=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_v, prev_d, prev_l);
                end
            end
            if ((m_axis_tvalid & m_axis_tready) != '0) begin
                prev_stall = 1'b0;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: v=%b d=%h l=%b", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (m_axis_tvalid != N'(1 << e.dest) || m_axis_tdata != e.data || m_axis_tlast != e.last) begin
                        n_fail++;
                        $display("FAIL beat: got v=%b d=%h l=%b, expected v=%b d=%h l=%b",
                                 m_axis_tvalid, m_axis_tdata, m_axis_tlast, N'(1 << e.dest), e.data, e.last);
                    end
                end
            end else begin
                prev_stall = (m_axis_tvalid != '0);
                prev_v = m_axis_tvalid;
                prev_d = m_axis_tdata;
                prev_l = m_axis_tlast;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Presents one beat and returns at posedge+1 after it is accepted.
    task automatic send_beat(input logic [IW-1:0] tid, input logic [DW-1:0] d, input logic l);
        s_axis_tvalid = 1'b1;
        s_axis_tid    = tid;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                @(posedge clk);
                #1;
                s_axis_tvalid = 1'b0;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: tready stuck low, tid=%0d data=%h", tid, d);
        s_axis_tvalid = 1'b0;
    endtask

    // Reference model: a packet goes whole to its first-beat index if it is < N, else counts one drop.
    task automatic send_pkt(input int tid, input int len, input logic [DW-1:0] base,
                            input int later_tid, input bit gaps);
        for (int i = 0; i < len; i++) begin
            int            t;
            logic [DW-1:0] d;
            logic          l;
            t = (i == 0) ? tid : ((later_tid < 0) ? int'($urandom_range(0, 3)) : later_tid);
            d = DW'(base * (i + 1));
            l = (i == len - 1);
            if (tid < int'(N)) begin
                beat_t b;
                b.dest = tid;
                b.data = d;
                b.last = l;
                exp_q.push_back(b);
            end else if (i == 0) begin
                exp_drops++;
            end
            send_beat(IW'(t), d, l);
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic settle();
        int k;
        for (k = 0; k < 5000 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats outstanding", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_drops();
        check("drop_count", 32'(drop_count), (exp_drops > 65535) ? 32'hFFFF : 32'(exp_drops));
        check("drop_pulses", 32'(drop_pulses), 32'(exp_drops));
    endtask

    initial begin
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tid    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_tdata", 32'(m_axis_tdata), 0);
        check("rst_tlast", 32'(m_axis_tlast), 0);
        check("rst_drop", 32'(drop), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        check("rst_tready", 32'(s_axis_tready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("tready_before_edge", 32'(s_axis_tready), 0);
        @(posedge clk);
        #1;
        check("tready_after_edge", 32'(s_axis_tready), 1);

        // Routing and destination lock
        send_pkt(2, 3, 16'h0011, 2, 0);
        settle();
        send_pkt(2, 3, 16'h0101, 1, 0);
        send_pkt(1, 2, 16'h0200, 1, 0);
        settle();

        // Backpressure on output 2 mid-packet
        bp_val  = 3'b011;
        bp_hold = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bp_done = 1'b0;
        fork
            begin
                send_pkt(2, 5, 16'h0A00, 2, 0);
                bp_done = 1'b1;
            end
        join_none
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            check("bp_tvalid", 32'(m_axis_tvalid), 32'b100);
            check("bp_tready", 32'(s_axis_tready), 0);
            check("bp_tdata", 32'(m_axis_tdata), 32'h0A00);
        end
        bp_hold = 1'b0;
        for (int k = 0; k < 200 && !bp_done; k++) @(posedge clk);
        check("bp_sender_done", 32'(bp_done), 1);
        settle();

        // Out-of-range packet, then a normal one
        send_pkt(3, 2, 16'h0700, 3, 0);
        settle();
        check_drops();
        send_pkt(0, 2, 16'h0300, 0, 0);
        settle();

        // Randomized traffic
        rand_ready = 1'b1;
        for (int p = 0; p < 300; p++)
            send_pkt(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), DW'($urandom), -1, 1);
        settle();
        rand_ready = 1'b0;
        settle();
        check_drops();

        // Drop counter saturation
        for (int p = 0; p < 65540; p++) send_pkt(3, 1, 16'h0001, 3, 0);
        settle();
        check_drops();
        check("sat_drop_count", 32'(drop_count), 32'hFFFF);

        // Reset in the middle of a routed packet
        bp_val  = '0;
        bp_hold = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send_beat(2'd1, 16'h0BEE, 1'b0);
        @(negedge clk);
        check("pre_reset_tvalid", 32'(m_axis_tvalid), 32'b010);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_drops   = 0;
        drop_pulses = 0;
        check("midrst_tvalid", 32'(m_axis_tvalid), 0);
        check("midrst_drop_count", 32'(drop_count), 0);
        check("midrst_tready", 32'(s_axis_tready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bp_hold = 1'b0;
        send_pkt(2, 2, 16'h0C00, 2, 0);
        settle();
        check_drops();
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_demux_decoder.md
# axis_demux_decoder

Stream demultiplexer that decodes a binary destination index into a one-hot output select. It routes each packet on a single AXI-stream input to one of N AXI-stream outputs, and is the decode-side counterpart to the priority-encoded arbiter/mux path. It locks the destination at each packet's first beat and holds it until `tlast`. It registers the output through a one-entry stage and discards packets whose index is out of range.

## Interface
- `N`, 4: number of output streams; N >= 2.
- `DW`, 16: data width.
- `IW`, $clog2(N): index width.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  DW  input data.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `s_axis_tlast`  in  1  end of packet.
- `s_axis_tid`  in  IW  destination index; sampled on first beat of packet only.
- `m_axis_tdata`  out  DW  output data, shared by all outputs.
- `m_axis_tlast`  out  1  output last, shared.
- `m_axis_tvalid`  out  N  one-hot valid; bit k = beat for output k.
- `m_axis_tready`  in  N  per-output ready.
- `drop`  out  1  one-cycle pulse per discarded packet.
- `drop_count`  out  16  saturating count of discarded packets.

## Operation
- Output register (ORB) holds `data`, `last` and one-hot `dest`. Empty when `m_axis_tvalid == 0`.
- States:
  - IDLE: awaiting first beat.
  - ROUTE: locked to `lock_id`.
  - DROP: discarding the remainder of a packet.
- Transitions, on an accepted beat (`s_axis_tvalid && s_axis_tready`):
  - IDLE, `tid < N`: load ORB with dest = 1<<tid and latch `lock_id = tid`.
    - `!tlast` -> ROUTE.
    - `tlast` -> stay IDLE.
  - IDLE, `tid >= N`: beat discarded and ORB untouched.
    - Register `drop` pulse and increment `drop_count` (saturate at 0xFFFF).
    - `!tlast` -> DROP.
    - `tlast` -> IDLE.
  - ROUTE: load ORB with dest = 1<<lock_id; `tid` ignored. `tlast` -> IDLE.
  - DROP: beat discarded. `tlast` -> IDLE.
- `s_axis_tready` is combinational: `rdy_en && (state == DROP || discard-case in IDLE || ORB empty || (m_axis_tready & m_axis_tvalid) != 0)`.
  - `rdy_en` is a flop cleared by reset and set on the first clock after `rst_n` rises.
- ORB update: on a downstream handshake with no new load, clear `m_axis_tvalid`. A simultaneous handshake and load replaces ORB contents, giving a full-throughput pass.
- ORB `dest` belongs to its own beat. A new packet to a different output may load while the ORB drains, subject to the ready rule above.
- Output data is stable while `m_axis_tvalid != 0` and the selected ready is low.

## Timing
- Reset (async assert) values:
  - `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `m_axis_tlast` = 0.
  - `drop` = 0, `drop_count` = 0.
  - state = IDLE, `lock_id` = 0, `rdy_en` = 0, so `s_axis_tready` = 0.
- Reset release is synchronous to `clk`. `s_axis_tready` may first assert in the cycle after the first edge with `rst_n` high.
- Latency: a beat accepted at edge t appears on `m_axis_*` after edge t. Sustained throughput is one beat/cycle when the selected ready is held high.
- `drop` is high for exactly the cycle after the accepting edge of a discarded first beat. Later beats of that packet do not pulse.
- Single-beat packets (`tlast` on first beat) never leave IDLE.
- Reset mid-packet: the partial packet is abandoned, the ORB is cleared, and the next accepted beat is treated as a first beat.
- At most one bit of `m_axis_tvalid` is set at any time.

## Test plan
- Reset release: hold `rst_n` = 0 and check all outputs are 0. Release and check `s_axis_tready` = 0 on the first edge and 1 on the next.
- Routing: send 3-beat packet tid = 2 (data 0x0011, 0x0022, 0x0033) with all ready = 1.
  - Expect `m_axis_tvalid` = 4'b0100 for 3 consecutive cycles, data in order, `tlast` on the third beat.
- Lock: same as above, but drive tid = 1 on beats 2–3. Expect all beats still on output 2; the next packet with tid = 1 goes to 4'b0010.
- Backpressure: `m_axis_tready[2]` = 0 for 4 cycles mid-packet.
  - Expect data held stable and `s_axis_tready` = 0 while the ORB is full. There is no loss or duplication once ready returns.
- Drop: with N = 3, send a 2-beat packet with tid = 3.
  - Expect no `m_axis_tvalid`, one `drop` pulse and `drop_count` = 1. The following tid = 0 packet routes normally.
- Saturation/reset: force 65536 dropped single-beat packets and expect `drop_count` = 0xFFFF. Then assert `rst_n` mid-packet and expect `drop_count` = 0, state IDLE and the ORB empty.
